dispatch_scheduler: RTL

DISPATCH_SCHEDULER -- requirements
Module: dispatch_scheduler

---
 rtl/dispatch_pkg.sv | 27 ++
 rtl/dispatch_scheduler_if.sv | 27 ++
 rtl/rs_credit_counter.sv | 41 ++++
 rtl/dispatch_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: station codes, defaults and shared types for dispatch.
// Optional perf counter: define DISPATCH_PERF_EN (see dispatch_scheduler).
package dispatch_pkg;

  localparam int NUM_RS_DEF   = 5;
  localparam int RS_DEPTH_DEF = 4;

  localparam logic [2:0] ST_ALU    = 3'd0;
  localparam logic [2:0] ST_BRANCH = 3'd1;
  localparam logic [2:0] ST_LDST   = 3'd2;
  localparam logic [2:0] ST_MUL    = 3'd3;
  localparam logic [2:0] ST_JMP    = 3'd4;

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] station;
    logic       req;
    logic       rw;
  } hold_t;

endpackage

// File: rtl/dispatch_scheduler_if.sv
// dispatch_scheduler_if: decode-to-dispatch valid/ready handshake.
// Decode drives through master, the scheduler consumes through slave.
interface dispatch_scheduler_if;

  logic       dec_valid;
  logic       dec_ready;
  logic [2:0] dec_rsstation;
  logic       dec_station_request;
  logic       dec_reg_write;

  modport master (
    output dec_valid,
    output dec_rsstation,
    output dec_station_request,
    output dec_reg_write,
    input  dec_ready
  );

  modport slave (
    input  dec_valid,
    input  dec_rsstation,
    input  dec_station_request,
    input  dec_reg_write,
    output dec_ready
  );

endinterface

// File: rtl/rs_credit_counter.sv
// rs_credit_counter: free-entry credits for one reservation station.
// Releasing at full credit is held off and latched as an overflow.
module rs_credit_counter #(
  parameter int RS_DEPTH = 4,
  parameter int CW       = $clog2(RS_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dispatch,
  input  logic          rel,
  input  logic          flush,
  output logic [CW-1:0] credit,
  output logic          has_space,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(RS_DEPTH);

  // a same-cycle release frees the slot the dispatch consumes
  assign has_space = (credit != '0) || rel;

  // credit bookkeeping; overflow stays set until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit   <= FULL;
      overflow <= 1'b0;
    end else if (flush) begin
      credit <= FULL;
    end else begin
      unique case (1'b1)
        dispatch && !rel: credit <= credit - CW'(1);
        rel && !dispatch: begin
          if (credit == FULL) overflow <= 1'b1;
          else                credit   <= credit + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler: one-entry holding register issuing to stations.
// Define DISPATCH_PERF_EN to build the stall_cycles counter.
module dispatch_scheduler
  import dispatch_pkg::*;
#(
  parameter int NUM_RS   = NUM_RS_DEF,
  parameter int RS_DEPTH = RS_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  dispatch_scheduler_if.slave dec,
  input  logic              rob_full,
  input  logic [NUM_RS-1:0] rs_release,
  input  logic              flush,
  output logic [NUM_RS-1:0] rs_dispatch,
  output logic              rob_alloc,
  output logic              regstat_write,
  output logic              illegal_station,
  output logic              credit_err,
  output logic [31:0]       stall_cycles
);

  localparam int CW = $clog2(RS_DEPTH + 1);

  state_t state;
  state_t state_nx;
  hold_t  hold;

  logic run_ok;
  logic bad_code;
  logic space;
  logic drop;
  logic issue;
  logic capture;

  logic [NUM_RS-1:0] rel;
  logic [NUM_RS-1:0] has_space;
  logic [NUM_RS-1:0] overflow;
  logic [NUM_RS-1:0][CW-1:0] credit;

  assign run_ok   = !flush && (state != S_FLUSH);
  assign rel      = rs_release & {NUM_RS{run_ok}};
  assign bad_code = int'(hold.station) >= NUM_RS;

  assign drop  = run_ok && hold.valid
              && hold.req && bad_code;
  assign issue = run_ok && hold.valid && !drop
              && !rob_full && space;

  assign dec.dec_ready = (state != S_FLUSH)
                      && (!hold.valid || issue);
  assign capture = dec.dec_valid
                && dec.dec_ready && !flush;

  assign rob_alloc       = issue;
  assign regstat_write   = issue && hold.rw;
  assign illegal_station = drop;
  assign credit_err      = |overflow;

  // room in the target station, or no station needed
  always_comb begin
    space = !hold.req;
    for (int i = 0; i < NUM_RS; i++) begin
      if (hold.station == 3'(i) && has_space[i])
        space = 1'b1;
    end
  end

  // one-hot write strobe to the requested station
  always_comb begin
    rs_dispatch = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_dispatch[i] = issue && hold.req
                    && (hold.station == 3'(i));
    end
  end

  for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
    rs_credit_counter #(
      .RS_DEPTH (RS_DEPTH),
      .CW       (CW)
    ) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .dispatch  (rs_dispatch[g]),
      .rel       (rel[g]),
      .flush     (!run_ok),
      .credit    (credit[g]),
      .has_space (has_space[g]),
      .overflow  (overflow[g])
    );
  end

  // credits can never climb past the station depth
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NUM_RS; i++)
        assert (credit[i] <= CW'(RS_DEPTH));
    end
  end

  // holding register: flush clears, capture replaces
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (!run_ok) begin
      hold <= '0;
    end else if (capture) begin
      hold.valid   <= 1'b1;
      hold.station <= dec.dec_rsstation;
      hold.req     <= dec.dec_station_request;
      hold.rw      <= dec.dec_reg_write;
    end else if (issue || drop) begin
      hold.valid <= 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RUN;
    else          state <= state_nx;
  end

  // next state: flush wins, FLUSH lasts one cycle
  always_comb begin
    state_nx = S_RUN;
    if (flush)
      state_nx = S_FLUSH;
    else if (state == S_FLUSH)
      state_nx = S_RUN;
    else if (hold.valid && !drop && !issue)
      state_nx = S_STALL;
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_q;

  // saturating count of cycles spent in STALL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (state == S_STALL && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
